// File: rtl/booth_select_sequencer.sv
// rtl/booth_select_sequencer.sv - radix-4 modified-Booth window sequencer for the multdiv multiplier
//
// Loads a signed multiplier and walks it two bits per step, presenting the
// 3-bit Booth window {q[2i+1], q[2i], q[2i-1]} (q[-1] = 0) on `select`.
// The consumer accepts each window with `advance`; it may stall indefinitely.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset
//   start       load `multiplier` and begin a new sequence (beats `advance`)
//   multiplier  signed operand, sampled only when `start` is high
//   advance     consumer accepted the current `select`
//   select      current Booth window, registered
//   sel_valid   `select` is meaningful this cycle
//   step        index of the current window, 0..STEPS-1
//   last        current window is the final one
//   busy        sequence in progress
//   done        one-cycle pulse after the final window is accepted

module booth_select_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEPS = WIDTH / 2,
  parameter int CW    = $clog2(WIDTH / 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplier,
  input  logic             advance,
  output logic [2:0]       select,
  output logic             sel_valid,
  output logic [CW-1:0]    step,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH:0]   sr, sr_n;
  logic [CW-1:0]    step_r, step_n;
  logic             done_r, done_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      sr     <= '0;
      step_r <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      step_r <= step_n;
      done_r <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    step_n  = step_r;
    done_n  = 1'b0;

    if (start) begin
      // The extra LSB is the implicit q[-1] = 0 of the first window.
      sr_n    = {multiplier, 1'b0};
      step_n  = '0;
      state_n = RUN;
    end else if (state == RUN && advance) begin
      if (step_r == LAST_STEP) begin
        // SR is left alone so `select` keeps the final window; it is
        // qualified off by sel_valid going low.
        state_n = IDLE;
        step_n  = '0;
        done_n  = 1'b1;
      end else begin
        // Sign-extending shift keeps the window correct for signed operands.
        sr_n   = {{2{sr[WIDTH]}}, sr[WIDTH:2]};
        step_n = step_r + 1'b1;
      end
    end
  end

  assign select    = sr[2:0];
  assign sel_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign step      = step_r;
  assign last      = (state == RUN) && (step_r == LAST_STEP);
  assign done      = done_r;

endmodule
